lsu_mem: RTL and testbench
==========================

Name: lsu_mem

Overview:
Multi-cycle load/store unit with private data memory. It serves the core's write-back state and replaces direct word-indexed mem[] accesses. Memory is byte-addressed and supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with a valid/ready handshake and configurable access latency. Misaligned, out-of-range and illegal-funct3 accesses are reported as faults rather than silently executed.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in memory; must be a power of two and at least 2.
WAIT_CYCLES, 0, extra stall cycles between request acceptance and response; range 0..15.

Ports:
clk  in  1  clock
rstn  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address (rs1 + imm)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and faults
resp_fault  out  1  access was rejected

Behaviour:
- States are IDLE, WAIT, RESP (plus CLEAR when the optional feature is compiled in).
- Reset values: req_ready=0 during the reset cycle; state=IDLE afterwards with req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; wait counter=0.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready; operands are latched that cycle.
  - With WAIT_CYCLES=0 the next state is RESP.
  - Otherwise the next state is WAIT with counter=WAIT_CYCLES.
- WAIT: counter decrements each cycle. When counter==1 the next state is RESP.
- Memory access happens on the clock edge entering RESP.
  - Stores update only the selected byte lanes.
  - Loads register the extracted data into resp_rdata.
- Latency: resp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
- RESP: resp_valid=1, req_ready=0. Outputs stay stable until resp_ready=1. On resp_ready the next state is IDLE and resp_valid drops the following cycle.
- There is no request/response overlap: req_ready=0 in WAIT and RESP.
- Word index is addr[log2(DEPTH_WORDS)+1:2]; the byte lane is addr[1:0].
- Load extraction:
  - LB and LBU take byte lane addr[1:0].
  - LH and LHU take half addr[1].
  - B/H loads sign-extend; BU/HU loads zero-extend.
- Store lanes:
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Fault conditions (fault=1, memory unchanged, rdata=0):
  - H/HU access with addr[0]=1.
  - W access with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- A fault still follows full WAIT/RESP timing.
- Highest address 4*DEPTH_WORDS-4 is legal; no wrap-around.
- Reset mid-operation aborts the access:
  - If the RESP write edge has not yet occurred, memory is unchanged.
  - All outputs return to reset values.
  - Memory contents are otherwise retained.

Optional Feature:
Macro LSU_INIT_CLEAR_EN.
- Defined: after rstn deasserts, the FSM enters CLEAR and writes 0 to one word per cycle from index 0 to DEPTH_WORDS-1. req_ready=0 throughout CLEAR; IDLE is entered after DEPTH_WORDS cycles. Reset during CLEAR restarts the sweep at 0.
- Undefined: there is no CLEAR state, memory contents are undefined at power-up, and IDLE is entered directly.

Decomposition:
- Shared package core_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - lsu_state_t enum.
  - Function lsu_load_ext(word, addr[1:0], funct3).
- One sub-module, lsu_ram: single-port byte-enable RAM with DEPTH_WORDS parameter, ports clk, we, be[3:0], idx, wdata, rdata (registered read).

Test Plan:
- WAIT_CYCLES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, fault=0; resp_valid exactly 1 cycle after each accept.
- Byte/half: SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LW @0x20 -> 0x800180xx, where xx is the lane-0 contents.
- Faults: LW @0x12, SH @0x23, LW @0x1000 (DEPTH_WORDS=1024) and funct3=011 load -> fault=1, rdata=0; a subsequent LW of the affected words shows no change.
- WAIT_CYCLES=3 with resp_ready held 0 for 5 cycles -> resp_valid rises 4 cycles after accept; rdata/fault stable and req_ready=0 until resp_ready; IDLE the cycle after.
- rstn pulsed low during WAIT of SW 0x12345678 @0x40 -> after reset resp_valid=0, req_ready=1, and LW @0x40 returns the prior value.
- With LSU_INIT_CLEAR_EN and DEPTH_WORDS=16 -> req_ready=0 for 16 cycles after reset; LW @0x3C -> 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared funct3 constants, LSU state type and load extraction helper
package core_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
`ifdef LSU_INIT_CLEAR_EN
    RESP,
    CLEAR
`else
    RESP
`endif
  } lsu_state_t;

  function automatic logic [31:0] lsu_load_ext(input logic [31:0] word, input logic [1:0] a, input logic [2:0] f3);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(word >> {a, 3'b000});
    h = a[1] ? word[31:16] : word[15:0];
    return f3 == F3_B  ? {{24{b[7]}}, b} :
           f3 == F3_H  ? {{16{h[15]}}, h} :
           f3 == F3_W  ? word :
           f3 == F3_BU ? {24'b0, b} :
           f3 == F3_HU ? {16'b0, h} : 32'b0;
  endfunction
endpackage

// File: rtl/lsu_ram.sv
// lsu_ram: single-port byte-enable RAM with registered read
module lsu_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  // byte-lane writes and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[idx];
  end
endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: multi-cycle RV32I load/store unit with private memory; LSU_INIT_CLEAR_EN adds a zeroing sweep after reset
module lsu_mem
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef LSU_INIT_CLEAR_EN
  localparam lsu_state_t RST_ST = CLEAR;
`else
  localparam lsu_state_t RST_ST = IDLE;
`endif

  lsu_state_t state, state_n;
  logic [3:0] cnt;
  logic l_we;
  logic [2:0] l_f3;
  logic [31:0] l_addr, l_wdata;
  logic accept, enter_resp;
  logic c_we, c_flt;
  logic [2:0] c_f3;
  logic [31:0] c_addr, c_wdata;
  logic [3:0] c_be;
  logic ram_we;
  logic [3:0] ram_be;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram_wdata, ram_rdata;
`ifdef LSU_INIT_CLEAR_EN
  logic [AW-1:0] clr;
`endif

  // in IDLE the live request drives decode so a zero-wait store can write on its accept edge
  assign accept  = req_valid && req_ready;
  assign c_we    = state == IDLE ? req_we     : l_we;
  assign c_f3    = state == IDLE ? req_funct3 : l_f3;
  assign c_addr  = state == IDLE ? req_addr   : l_addr;
  assign c_wdata = state == IDLE ? req_wdata  : l_wdata;
  assign c_flt   = (c_f3[1:0] == 2'b01 && c_addr[0]) ||
                   (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) ||
                   ((c_addr >> (AW + 2)) != '0) ||
                   (c_we ? c_f3 > F3_W : (c_f3 == 3'b011 || c_f3[2:1] == 2'b11));
  assign c_be    = c_f3[1:0] == 2'b00 ? 4'b0001 << c_addr[1:0] :
                   c_f3[1:0] == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign enter_resp = state_n == RESP && state != RESP;

  // state register
  always_ff @(posedge clk)
    state <= !rstn ? RST_ST : state_n;

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
      WAIT:  state_n = cnt == 4'd1 ? RESP : WAIT;
      RESP:  state_n = resp_ready ? IDLE : RESP;
`ifdef LSU_INIT_CLEAR_EN
      CLEAR: state_n = clr == AW'(DEPTH_WORDS - 1) ? IDLE : CLEAR;
`endif
      default: state_n = IDLE;
    endcase
  end

  // outputs; gated by rstn so the reset cycle itself shows reset values
  always_comb begin
    req_ready  = rstn && state == IDLE;
    resp_valid = rstn && state == RESP;
    resp_fault = resp_valid && c_flt;
    resp_rdata = resp_valid && !c_we && !c_flt ? lsu_load_ext(ram_rdata, c_addr[1:0], c_f3) : 32'b0;
  end

  // operand latch and wait counter
  always_ff @(posedge clk)
    if (!rstn) begin
      cnt <= '0;
      l_we <= 1'b0;
      l_f3 <= '0;
      l_addr <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      cnt <= 4'(WAIT_CYCLES);
      l_we <= req_we;
      l_f3 <= req_funct3;
      l_addr <= req_addr;
      l_wdata <= req_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end

`ifdef LSU_INIT_CLEAR_EN
  // sweep index, restarted by every reset
  always_ff @(posedge clk)
    clr <= !rstn || state != CLEAR ? '0 : clr + AW'(1);
`endif

  // RAM port: legal stores write only on the edge entering RESP
  always_comb begin
    ram_we    = rstn && enter_resp && c_we && !c_flt;
    ram_be    = c_be;
    ram_idx   = c_addr[AW+1:2];
    ram_wdata = c_f3[1:0] == 2'b00 ? {4{c_wdata[7:0]}} :
                c_f3[1:0] == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
`ifdef LSU_INIT_CLEAR_EN
    ram_we    = state == CLEAR ? rstn : ram_we;
    ram_be    = state == CLEAR ? 4'b1111 : ram_be;
    ram_idx   = state == CLEAR ? clr : ram_idx;
    ram_wdata = state == CLEAR ? 32'b0 : ram_wdata;
`endif
  end

  lsu_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk(clk),
    .we(ram_we),
    .be(ram_be),
    .idx(ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: scoreboard bench for lsu_mem (u0: W=0, u1: W=3, u2: 16 words)
module tb_lsu_mem;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [2:0] vld = '0;
  logic r_we = 1'b0;
  logic [2:0] r_f3 = '0;
  logic [31:0] r_addr = '0, r_wdata = '0;
  logic resp_ready = 1'b1;
  logic [2:0] rr, rv, fl, prv;
  logic [31:0] rd [3];
  logic [32:0] q [3][$];
  logic [32:0] mon_e;
  int wc [3] = '{0, 3, 0};
  int vecs = 0, fails = 0;
`ifdef LSU_INIT_CLEAR_EN
  localparam int CLR_CYC = 16;
`else
  localparam int CLR_CYC = 0;
`endif

  always #5 clk = ~clk;

  lsu_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rstn(rstn), .req_valid(vld[0]), .req_ready(rr[0]), .req_we(r_we),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rv[0]),
    .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_fault(fl[0]));
  lsu_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rstn(rstn), .req_valid(vld[1]), .req_ready(rr[1]), .req_we(r_we),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rv[1]),
    .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_fault(fl[1]));
  lsu_mem #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rstn(rstn), .req_valid(vld[2]), .req_ready(rr[2]), .req_we(r_we),
    .req_funct3(r_f3), .req_addr(r_addr), .req_wdata(r_wdata), .resp_valid(rv[2]),
    .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_fault(fl[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // monitor: compare each newly presented response against the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rstn && rv[i] && !prv[i]) begin
        if (q[i].size() == 0) begin
          vecs++;
          fails++;
          $display("FAIL spurious response u%0d: rdata %h fault %b", i, rd[i], fl[i]);
        end else begin
          mon_e = q[i].pop_front();
          chk($sformatf("u%0d rdata", i), rd[i], mon_e[31:0]);
          chk($sformatf("u%0d fault", i), 32'(fl[i]), 32'(mon_e[32]));
        end
      end
    prv = rstn ? rv : '0;
  end

  task automatic xfer(input int u, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ef, input int hold);
    int n;
    n = 0;
    while (!rr[u] && n < 5000) begin tick(); n++; end
    chk("req_ready before issue", 32'(rr[u]), 1);
    q[u].push_back({ef, ed});
    vld[u] = 1'b1;
    r_we = we;
    r_f3 = f3;
    r_addr = a;
    r_wdata = wd;
    resp_ready = hold == 0;
    tick();
    vld[u] = 1'b0;
    n = 1;
    while (!rv[u] && n < 50) begin tick(); n++; end
    chk("latency", n, wc[u] + 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold resp_valid", 32'(rv[u]), 1);
      chk("hold req_ready", 32'(rr[u]), 0);
      chk("hold rdata", rd[u], ed);
      chk("hold fault", 32'(fl[u]), 32'(ef));
    end
    resp_ready = 1'b1;
    tick();
    chk("resp_valid dropped", 32'(rv[u]), 0);
    chk("idle after resp", 32'(rr[u]), 1);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset req_ready", 32'(rr[i]), 0);
      chk("reset resp_valid", 32'(rv[i]), 0);
      chk("reset rdata", rd[i], 0);
      chk("reset fault", 32'(fl[i]), 0);
    end
    rstn = 1'b1;
    #1;
    n = 0;
    while (!rr[2] && n < 100) begin @(posedge clk); #1; n++; end
    chk("clear cycles", n, CLR_CYC);
    tick();

    // word, byte and half accesses
    xfer(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
    xfer(0, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 0);
    xfer(0, 1, F3_W,  32'h20, 32'h11223344, 32'h0,        0, 0);
    xfer(0, 1, F3_B,  32'h21, 32'h00000080, 32'h0,        0, 0);
    xfer(0, 0, F3_B,  32'h21, 32'h0,        32'hFFFFFF80, 0, 0);
    xfer(0, 0, F3_BU, 32'h21, 32'h0,        32'h00000080, 0, 0);
    xfer(0, 1, F3_H,  32'h22, 32'h00008001, 32'h0,        0, 0);
    xfer(0, 0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 0, 0);
    xfer(0, 0, F3_HU, 32'h22, 32'h0,        32'h00008001, 0, 0);
    xfer(0, 0, F3_W,  32'h20, 32'h0,        32'h80018044, 0, 0);
    xfer(0, 0, F3_B,  32'h20, 32'h0,        32'h00000044, 0, 0);
    xfer(0, 0, F3_H,  32'h20, 32'h0,        32'hFFFF8044, 0, 0);
    xfer(0, 0, F3_BU, 32'h23, 32'h0,        32'h00000080, 0, 0);
    // faults leave memory untouched
    xfer(0, 0, F3_W,   32'h12,   32'h0,        32'h0, 1, 0);
    xfer(0, 1, F3_H,   32'h23,   32'h0000FFFF, 32'h0, 1, 0);
    xfer(0, 0, F3_W,   32'h1000, 32'h0,        32'h0, 1, 0);
    xfer(0, 0, 3'b011, 32'h10,   32'h0,        32'h0, 1, 0);
    xfer(0, 1, 3'b100, 32'h10,   32'hFFFFFFFF, 32'h0, 1, 0);
    xfer(0, 1, F3_W,   32'h12,   32'h0,        32'h0, 1, 0);
    xfer(0, 0, F3_HU,  32'h11,   32'h0,        32'h0, 1, 0);
    xfer(0, 0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF, 0, 0);
    xfer(0, 0, F3_W,   32'h20,   32'h0,        32'h80018044, 0, 0);
    // highest word is legal
    xfer(0, 1, F3_W, 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 0);
    xfer(0, 0, F3_W, 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 0);
    // 16-word instance boundaries
    xfer(2, 0, F3_W, 32'h40, 32'h0, 32'h0, 1, 0);
`ifdef LSU_INIT_CLEAR_EN
    xfer(2, 0, F3_W, 32'h3C, 32'h0, 32'h0, 0, 0);
`endif
    xfer(2, 1, F3_W, 32'h3C, 32'hA5A5A5A5, 32'h0,        0, 0);
    xfer(2, 0, F3_W, 32'h3C, 32'h0,        32'hA5A5A5A5, 0, 0);
    // wait-state instance with a stalled consumer
    xfer(1, 1, F3_W, 32'h40, 32'h0BADF00D, 32'h0,        0, 0);
    xfer(1, 0, F3_W, 32'h40, 32'h0,        32'h0BADF00D, 0, 5);
    xfer(1, 0, F3_W, 32'h13, 32'h0,        32'h0,        1, 0);

    // reset during WAIT aborts the store
    vld[1] = 1'b1;
    r_we = 1'b1;
    r_f3 = F3_W;
    r_addr = 32'h40;
    r_wdata = 32'h12345678;
    tick();
    vld[1] = 1'b0;
    tick();
    chk("abort pre-reset resp_valid", 32'(rv[1]), 0);
    rstn = 1'b0;
    tick();
    chk("abort reset req_ready", 32'(rr[1]), 0);
    chk("abort reset resp_valid", 32'(rv[1]), 0);
    rstn = 1'b1;
    #1;
    n = 0;
    while (!rr[1] && n < 5000) begin tick(); n++; end
    chk("post-reset req_ready", 32'(rr[1]), 1);
    chk("post-reset resp_valid", 32'(rv[1]), 0);
`ifdef LSU_INIT_CLEAR_EN
    xfer(1, 0, F3_W, 32'h40, 32'h0, 32'h0, 0, 0);
`else
    xfer(1, 0, F3_W, 32'h40, 32'h0, 32'h0BADF00D, 0, 0);
`endif

    tick();
    for (int i = 0; i < 3; i++) chk($sformatf("u%0d scoreboard drained", i), q[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
